uart_debug_host: RTL
====================

UART_DEBUG_HOST -- requirements
Module: uart_debug_host

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000000, giving the number of cycles to wait for a response byte before flagging an error.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have AXI-lite responder write ports:
- aw_valid in 1; aw_ready out 1; aw_addr in 18.
- w_valid in 1; w_ready out 1; w_data in 16.
- b_valid out 1; b_ready in 1; b_resp out 2.
REQ-005 SHALL have AXI-lite responder read ports:
- ar_valid in 1; ar_ready out 1; ar_addr in 18.
- r_valid out 1; r_ready in 1; r_data out 16; r_resp out 2.
REQ-006 SHALL have UART byte-stream ports:
- uart_tx out 8; uart_tx_valid out 1; uart_tx_ready in 1: command bytes to the transmitter.
- uart_rx in 8; uart_rx_valid in 1; uart_rx_ready out 1: response bytes from the receiver.

Function
REQ-007 SHALL translate each AXI transaction into a serial debug command, send it, parse the reply, and return the AXI response; one transaction is outstanding at a time.
REQ-008 SHALL implement states IDLE, SEND, WAIT, RESP.
REQ-009 SHALL, in IDLE with aw_valid and w_valid both high, pulse aw_ready and w_ready together for one cycle, latch the address and data, and enter SEND with the write command.
REQ-010 SHALL, in IDLE with ar_valid high and no complete write pair pending, pulse ar_ready for one cycle, latch the address, and enter SEND with the read command.
REQ-011 SHALL give a write priority over a read when both are presentable in the same cycle; the read is accepted in the first IDLE cycle after the write completes.
REQ-012 SHALL never accept aw without w, or w without aw.
REQ-013 SHALL send a write as 6 bytes: 0x57, {6'b0, addr[17:16]}, addr[15:8], addr[7:0], data[15:8], data[7:0].
REQ-014 SHALL send a read as 4 bytes: 0x52, {6'b0, addr[17:16]}, addr[15:8], addr[7:0].
REQ-015 SHALL hold uart_tx_valid high in SEND; a byte is consumed only on a cycle with uart_tx_valid and uart_tx_ready both high; uart_tx is stable while it waits.
REQ-016 SHALL move from SEND to WAIT in the cycle after the last byte is consumed, with the timeout counter cleared.
REQ-017 SHALL hold uart_rx_ready high in IDLE and WAIT and low in SEND and RESP; bytes accepted in IDLE are discarded.
REQ-018 SHALL handle write replies in WAIT: one byte; 0x4B gives b_resp 2'b00, any other value gives 2'b10.
REQ-019 SHALL handle read replies in WAIT: two bytes, MSB first, assembled into r_data with r_resp 2'b00.
REQ-020 SHALL clear the timeout counter on every accepted reply byte.
REQ-021 SHALL, if the counter reaches TIMEOUT-1 in WAIT, set resp 2'b10 (r_data 16'h0000 for a read) and go to RESP; a byte arriving in that same cycle is discarded.
REQ-022 SHALL, in RESP, hold b_valid or r_valid high with stable data until b_ready or r_ready is sampled high, then return to IDLE in the next cycle.
REQ-023 SHALL NOT assert b_valid and r_valid together.

Reset
REQ-024 SHALL, when rst is high, synchronously force IDLE and clear the byte index and timeout counter.
REQ-025 SHALL drive the following to 0 while rst is high and in the first cycle after: aw_ready, w_ready, ar_ready, b_valid, r_valid, uart_tx_valid, b_resp, r_resp, r_data, uart_tx.
REQ-026 SHALL, on rst mid-transaction, abandon the transaction without issuing a response; uart_rx_ready is 1 in the first cycle after reset.

Verification
REQ-027 SHALL cover write OK: aw_addr 18'h2_1234, w_data 16'hBEEF, tx always ready, reply 0x4B -> tx bytes 57 02 12 34 BE EF; then b_valid with b_resp 00.
REQ-028 SHALL cover read: ar_addr 18'h0_00A5, replies 0x12 then 0x34 -> tx bytes 52 00 00 A5; then r_valid with r_data 16'h1234 and r_resp 00.
REQ-029 SHALL cover timeout: TIMEOUT=16, read with no reply -> r_valid TIMEOUT cycles after entering WAIT, r_resp 10, r_data 0000.
REQ-030 SHALL cover simultaneous requests with backpressure: aw, w and ar valid in the same cycle, uart_tx_ready toggling -> write sent first with no byte duplicated or dropped; ar_ready only after b_ready handshake; write reply 0x00 -> b_resp 10.
REQ-031 SHALL cover reset mid-SEND: rst asserted after 2 bytes -> all outputs 0 the next cycle; a subsequent read runs normally.

Source files
------------

// File: rtl/uart_debug_host.sv
// Bridges AXI-lite single-beat reads/writes onto a UART byte-stream debug protocol.
// One transaction in flight: command bytes out, reply bytes in, AXI response back.
module uart_debug_host #(
   parameter int TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        aw_valid,
   output logic        aw_ready,
   input  logic [17:0] aw_addr,
   input  logic        w_valid,
   output logic        w_ready,
   input  logic [15:0] w_data,
   output logic        b_valid,
   input  logic        b_ready,
   output logic [1:0]  b_resp,
   input  logic        ar_valid,
   output logic        ar_ready,
   input  logic [17:0] ar_addr,
   output logic        r_valid,
   input  logic        r_ready,
   output logic [15:0] r_data,
   output logic [1:0]  r_resp,
   output logic [7:0]  uart_tx,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] ACK    = 8'h4B;

   // Byte idx of the outgoing command frame; bytes 4..5 only exist for writes.
   function automatic logic [7:0] cmd_byte(input logic wr, input logic [2:0] idx,
                                           input logic [17:0] addr, input logic [15:0] data);
      case (idx)
         3'd0:    cmd_byte = wr ? CMD_WR : CMD_RD;
         3'd1:    cmd_byte = {6'b000000, addr[17:16]};
         3'd2:    cmd_byte = addr[15:8];
         3'd3:    cmd_byte = addr[7:0];
         3'd4:    cmd_byte = data[15:8];
         3'd5:    cmd_byte = data[7:0];
         default: cmd_byte = 8'h00;
      endcase
   endfunction

   logic [1:0]    state_r, state_s;
   logic          is_wr_r, is_wr_s;
   logic [17:0]   addr_r, addr_s;
   logic [15:0]   data_r, data_s;
   logic [2:0]    idx_r, idx_s, last_idx_s;
   logic [CW-1:0] tmo_r, tmo_s;
   logic [7:0]    hi_r, hi_s;
   logic          got_hi_r, got_hi_s;
   logic          aw_ready_r, aw_ready_s;
   logic          w_ready_r, w_ready_s;
   logic          ar_ready_r, ar_ready_s;
   logic          b_valid_r, b_valid_s;
   logic          r_valid_r, r_valid_s;
   logic [1:0]    b_resp_r, b_resp_s;
   logic [1:0]    r_resp_r, r_resp_s;
   logic [15:0]   r_data_r, r_data_s;
   logic [7:0]    tx_r, tx_s;
   logic          tx_valid_r, tx_valid_s;
   logic          rx_ready_r, rx_ready_s;

   // Next-state and next-output computation; every output is registered from these.
   always_comb begin
      state_s    = state_r;
      is_wr_s    = is_wr_r;
      addr_s     = addr_r;
      data_s     = data_r;
      idx_s      = idx_r;
      tmo_s      = tmo_r;
      hi_s       = hi_r;
      got_hi_s   = got_hi_r;
      aw_ready_s = 1'b0;
      w_ready_s  = 1'b0;
      ar_ready_s = 1'b0;
      b_valid_s  = b_valid_r;
      r_valid_s  = r_valid_r;
      b_resp_s   = b_resp_r;
      r_resp_s   = r_resp_r;
      r_data_s   = r_data_r;
      tx_s       = tx_r;
      tx_valid_s = tx_valid_r;
      last_idx_s = is_wr_r ? 3'd5 : 3'd3;

      case (state_r)
         IDLE: begin
            if (aw_valid && w_valid) begin
               aw_ready_s = 1'b1;
               w_ready_s  = 1'b1;
               is_wr_s    = 1'b1;
               addr_s     = aw_addr;
               data_s     = w_data;
               idx_s      = 3'd0;
               tx_s       = CMD_WR;
               tx_valid_s = 1'b1;
               state_s    = SEND;
            end else if (ar_valid) begin
               ar_ready_s = 1'b1;
               is_wr_s    = 1'b0;
               addr_s     = ar_addr;
               idx_s      = 3'd0;
               tx_s       = CMD_RD;
               tx_valid_s = 1'b1;
               state_s    = SEND;
            end else begin
               idx_s      = 3'd0;
               state_s    = IDLE;
            end
         end
         SEND: begin
            // uart_tx_valid is high throughout SEND, so tx_ready alone marks consumption.
            if (uart_tx_ready) begin
               if (idx_r == last_idx_s) begin
                  tx_valid_s = 1'b0;
                  idx_s      = 3'd0;
                  tmo_s      = '0;
                  got_hi_s   = 1'b0;
                  state_s    = WAIT;
               end else begin
                  idx_s      = idx_r + 3'd1;
                  tx_s       = cmd_byte(is_wr_r, idx_r + 3'd1, addr_r, data_r);
               end
            end else begin
               tx_s = tx_r;
            end
         end
         WAIT: begin
            // Timeout wins over a byte arriving in the same cycle.
            if (tmo_r == TMO_LAST) begin
               if (is_wr_r) begin
                  b_valid_s = 1'b1;
                  b_resp_s  = 2'b10;
               end else begin
                  r_valid_s = 1'b1;
                  r_resp_s  = 2'b10;
                  r_data_s  = 16'h0000;
               end
               state_s = RESP;
            end else if (uart_rx_valid && rx_ready_r) begin
               tmo_s = '0;
               if (is_wr_r) begin
                  b_valid_s = 1'b1;
                  b_resp_s  = (uart_rx == ACK) ? 2'b00 : 2'b10;
                  state_s   = RESP;
               end else if (got_hi_r) begin
                  r_valid_s = 1'b1;
                  r_resp_s  = 2'b00;
                  r_data_s  = {hi_r, uart_rx};
                  state_s   = RESP;
               end else begin
                  hi_s      = uart_rx;
                  got_hi_s  = 1'b1;
               end
            end else begin
               tmo_s = tmo_r + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         RESP: begin
            if (is_wr_r ? b_ready : r_ready) begin
               b_valid_s = 1'b0;
               r_valid_s = 1'b0;
               state_s   = IDLE;
            end else begin
               state_s   = RESP;
            end
         end
         default: begin
            tx_valid_s = 1'b0;
            state_s    = IDLE;
         end
      endcase

      rx_ready_s = (state_s == IDLE) || (state_s == WAIT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         is_wr_r    <= 1'b0;
         addr_r     <= 18'h00000;
         data_r     <= 16'h0000;
         idx_r      <= 3'd0;
         tmo_r      <= '0;
         hi_r       <= 8'h00;
         got_hi_r   <= 1'b0;
         aw_ready_r <= 1'b0;
         w_ready_r  <= 1'b0;
         ar_ready_r <= 1'b0;
         b_valid_r  <= 1'b0;
         r_valid_r  <= 1'b0;
         b_resp_r   <= 2'b00;
         r_resp_r   <= 2'b00;
         r_data_r   <= 16'h0000;
         tx_r       <= 8'h00;
         tx_valid_r <= 1'b0;
         rx_ready_r <= 1'b1;
      end else begin
         state_r    <= state_s;
         is_wr_r    <= is_wr_s;
         addr_r     <= addr_s;
         data_r     <= data_s;
         idx_r      <= idx_s;
         tmo_r      <= tmo_s;
         hi_r       <= hi_s;
         got_hi_r   <= got_hi_s;
         aw_ready_r <= aw_ready_s;
         w_ready_r  <= w_ready_s;
         ar_ready_r <= ar_ready_s;
         b_valid_r  <= b_valid_s;
         r_valid_r  <= r_valid_s;
         b_resp_r   <= b_resp_s;
         r_resp_r   <= r_resp_s;
         r_data_r   <= r_data_s;
         tx_r       <= tx_s;
         tx_valid_r <= tx_valid_s;
         rx_ready_r <= rx_ready_s;
      end
   end

   assign aw_ready      = aw_ready_r;
   assign w_ready       = w_ready_r;
   assign ar_ready      = ar_ready_r;
   assign b_valid       = b_valid_r;
   assign r_valid       = r_valid_r;
   assign b_resp        = b_resp_r;
   assign r_resp        = r_resp_r;
   assign r_data        = r_data_r;
   assign uart_tx       = tx_r;
   assign uart_tx_valid = tx_valid_r;
   assign uart_rx_ready = rx_ready_r;

endmodule
